// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy state and
// per-stage bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int IF_ID_CTRL_W  = 4;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_CTRL_W = 10;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 96;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Reusable pipeline-stage register with valid/ready handshake and a 2-entry
// skid buffer, so in_ready is taken straight from the state register.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = MEM_WB_CTRL_W,
    parameter int DATA_W         = MEM_WB_DATA_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    pipe_state_t       state;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic              accept, drain;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = 2'(state);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (ZERO_ON_BUBBLE) begin
                m_ctrl <= '0;
                m_data <= '0;
                s_ctrl <= '0;
                s_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (accept) begin
                        state  <= TWO;
                        s_ctrl <= in_ctrl;
                        s_data <= in_data;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can move us
                    if (drain) begin
                        state  <= ONE;
                        m_ctrl <= s_ctrl;
                        m_data <= s_data;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // M keeps its last value after a drain; mask it when bubbles read as zero
    assign out_ctrl = (ZERO_ON_BUBBLE && !out_valid) ? '0 : m_ctrl;
    assign out_data = (ZERO_ON_BUBBLE && !out_valid) ? '0 : m_data;

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid & ~out_ready),
        .clr     (stall_clr),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a reference occupancy/stall model and
// an expected-entry queue are checked on every falling edge.
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 96;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;
    logic          stall_clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CW+DW-1:0] sb[$];
    int               mocc   = 0;
    int               mstall = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W         (CW),
        .DATA_W         (DW),
        .ZERO_ON_BUBBLE (1'b1),
        .STALL_CNT_W    (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    task automatic chk(input string tag, input logic [CW+DW-1:0] obs, input logic [CW+DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare current outputs against the model, then advance the
    // model to what the next rising edge must produce.
    initial begin
        logic             acc, drn;
        logic [CW+DW-1:0] front;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                #1;
                mocc   = 0;
                mstall = 0;
                sb.delete();
                chk("rst_in_ready",  (CW+DW)'(in_ready),  (CW+DW)'(1));
                chk("rst_out_valid", (CW+DW)'(out_valid), '0);
                chk("rst_occupancy", (CW+DW)'(occupancy), '0);
                chk("rst_out_bus",   {out_ctrl, out_data}, '0);
                chk("rst_stall_cnt", (CW+DW)'(stall_cnt), '0);
            end else begin
                acc = in_valid && (mocc != 2);
                drn = (mocc != 0) && out_ready;
                chk("in_ready",  (CW+DW)'(in_ready),  (CW+DW)'(mocc != 2));
                chk("out_valid", (CW+DW)'(out_valid), (CW+DW)'(mocc != 0));
                chk("occupancy", (CW+DW)'(occupancy), (CW+DW)'(mocc));
                chk("stall_cnt", (CW+DW)'(stall_cnt), (CW+DW)'(mstall));
                if (mocc != 0 && sb.size() > 0) begin
                    front = sb[0];
                    chk("out_bus", {out_ctrl, out_data}, front);
                end else begin
                    chk("bubble_zero", {out_ctrl, out_data}, '0);
                end
                if (stall_clr)
                    mstall = 0;
                else if (mocc != 0 && !out_ready && mstall != (1 << SW) - 1)
                    mstall++;
                if (flush) begin
                    mocc = 0;
                    sb.delete();
                end else begin
                    if (drn) void'(sb.pop_front());
                    if (acc) sb.push_back({in_ctrl, in_data});
                    mocc = mocc + int'(acc) - int'(drn);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = {$urandom, $urandom, $urandom};
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '0;
        in_data   = 96'hA5;

        // Reset held with a pending input; it must be taken at the first edge after release
        step(3);
        reset_n = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step(2);

        // Streaming at full rate
        for (int i = 1; i <= 16; i++) put(CW'(i));
        in_valid = 1'b0;
        step(3);

        // Backpressure: 03 must wait until the skid slot frees
        out_ready = 1'b0;
        put(8'h01);
        put(8'h02);
        put(8'h03);
        step(3);
        out_ready = 1'b1;
        step(2);
        in_valid = 1'b0;
        step(3);

        // Flush while full, with a simultaneous input that must be dropped
        out_ready = 1'b0;
        put(8'h21);
        put(8'h22);
        flush = 1'b1;
        put(8'h77);
        flush    = 1'b0;
        in_valid = 1'b0;
        step(2);
        out_ready = 1'b1;
        put(8'h31);
        put(8'h32);
        in_valid = 1'b0;
        step(3);

        // Stall counter saturation and clear
        out_ready = 1'b0;
        put(8'h41);
        in_valid = 1'b0;
        step(20);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        step(4);
        out_ready = 1'b1;
        step(2);

        // Asynchronous reset pulse between edges while full
        out_ready = 1'b0;
        put(8'h51);
        put(8'h52);
        in_valid = 1'b0;
        step(1);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step(2);
        out_ready = 1'b1;
        put(8'h61);
        put(8'h62);
        in_valid = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
